// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: forward AES SubBytes engine, time-multiplexed.
// A 128-bit state is accepted over a valid/ready handshake. Its 16 bytes are
// substituted SBOX_LANES bytes per cycle over NUM_STEPS = 16/SBOX_LANES cycles,
// in ascending byte order. The result is then presented over a valid/ready
// handshake.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  D_in holds a valid state
//   in_ready  block accepts a state (IDLE only)
//   D_in      input state, byte i = D_in[8i+7:8i]
//   out_valid D_out holds a completed result (DONE only)
//   out_ready downstream accepts D_out
//   D_out     substituted state, byte i = S(D_in byte i)
//
// S_box: FIPS-197 forward S-box, combinational byte lookup.
//   in_byte   byte to substitute
//   out_byte  S(in_byte)

module S_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = TABLE[in_byte];

endmodule

module sub_bytes_seq #(
  parameter int unsigned SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] D_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] D_out
);

  localparam int unsigned NUM_STEPS = 16 / SBOX_LANES;
  localparam int unsigned STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_next;

  logic [STEP_W-1:0] step;
  logic [15:0][7:0]  work;
  logic [15:0][7:0]  work_sub;

  logic [7:0] lane_in  [SBOX_LANES];
  logic [7:0] lane_out [SBOX_LANES];
  logic [3:0] byte_idx [SBOX_LANES];

  // Lane l always serves byte step*SBOX_LANES + l of the current group.
  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    assign byte_idx[l] = 4'(32'(step) * SBOX_LANES + 32'(l));
    assign lane_in[l]  = work[byte_idx[l]];

    S_box u_sbox (
      .in_byte  (lane_in[l]),
      .out_byte (lane_out[l])
    );
  end

  // Work register with the current group replaced; on the last step this is
  // the fully substituted state, so D_out loads it directly.
  always_comb begin
    work_sub = work;
    for (int unsigned i = 0; i < SBOX_LANES; i++) begin
      work_sub[byte_idx[i]] = lane_out[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (step == LAST_STEP) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step  <= '0;
      work  <= '0;
      D_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work <= D_in;
            step <= '0;
          end
        end
        BUSY: begin
          work <= work_sub;
          if (step == LAST_STEP) begin
            D_out <= work_sub;
            step  <= '0;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Testbench for sub_bytes_seq. A default (4-lane) instance is exercised with
// directed vectors; four more instances (1, 2, 8, 16 lanes) share a separate
// stimulus to check data and latency across lane counts.

module tb_sub_bytes_seq;

  localparam logic [127:0] KNOWN_IN  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] KNOWN_OUT = 128'h1628c14beaaceec4f533fc1bc3938263;
  localparam logic [127:0] ZERO_OUT  = {16{8'h63}};
  localparam logic [127:0] SEQ_IN    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_OUT   = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] B53_IN    = 128'h00000000000000000000000000000053;
  localparam logic [127:0] B53_OUT   = 128'h636363636363636363636363636363ed;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] D_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] D_out;

  logic         s_in_valid = 1'b0;
  logic [127:0] s_D_in = '0;
  logic [127:0] s_exp = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic         ov_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_seq #(.SBOX_LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D_in      (D_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D_out     (D_out)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Main monitor: acceptance times, latency on out_valid rise, data on transfer.
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc + 1);
    if (out_valid && !ov_prev) begin
      if (acc_q.size() == 0) check("latency_orphan", 128'd1, 128'd0);
      else check("latency", 128'(cyc - acc_q.pop_front()), 128'd4);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("data_orphan", D_out, 128'hx);
      else check("data", D_out, exp_q.pop_front());
    end
    ov_prev = out_valid;
  end

  always @(posedge rst) acc_q.delete();

  // Lane-count sweep instances.
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    logic         ir, ov;
    logic [127:0] dout;
    logic [127:0] eq [$];
    int           aq [$];
    logic         ovp = 1'b0;
    int           n_got = 0;

    sub_bytes_seq #(.SBOX_LANES(L)) u (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_in_valid),
      .in_ready  (ir),
      .D_in      (s_D_in),
      .out_valid (ov),
      .out_ready (1'b1),
      .D_out     (dout)
    );

    always @(negedge clk) begin
      if (s_in_valid && ir) begin
        aq.push_back(cyc + 1);
        eq.push_back(s_exp);
      end
      if (ov && !ovp) begin
        if (aq.size() == 0) check($sformatf("sw%0d_lat_orphan", L), 128'd1, 128'd0);
        else check($sformatf("sw%0d_latency", L), 128'(cyc - aq.pop_front()), 128'(16 / L));
      end
      if (ov) begin
        n_got++;
        if (eq.size() == 0) check($sformatf("sw%0d_orphan", L), dout, 128'hx);
        else check($sformatf("sw%0d_data", L), dout, eq.pop_front());
      end
      ovp = ov;
    end
  end

  // Drives D_in with in_valid high until accepted; returns the accepting edge.
  task automatic send(input logic [127:0] d, output int acc);
    bit ok = 1'b0;
    D_in = d;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1;
    bit seen;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_D_out", D_out, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero block and known vector, free-flowing.
    exp_q.push_back(ZERO_OUT);
    send('0, a0);
    wait_drain();
    exp_q.push_back(KNOWN_OUT);
    send(KNOWN_IN, a0);
    wait_drain();

    // Backpressure: hold out_ready low for 10 cycles.
    out_ready = 1'b0;
    exp_q.push_back(KNOWN_OUT);
    send(KNOWN_IN, a0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_out_valid_seen", 128'(seen), 128'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", 128'(out_valid), 128'd1);
      check("bp_hold_in_ready", 128'(in_ready), 128'd0);
      check("bp_hold_data", D_out, KNOWN_OUT);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check("bp_valid_fell", 128'(out_valid), 128'd0);
    check("bp_in_ready_rose", 128'(in_ready), 128'd1);
    check("bp_data_kept", D_out, KNOWN_OUT);
    @(posedge clk); #1;

    // in_valid held through BUSY/DONE: second state waits for IDLE.
    exp_q.push_back(SEQ_OUT);
    exp_q.push_back(KNOWN_OUT);
    send(SEQ_IN, a0);
    send(KNOWN_IN, a1);
    check("b2b_spacing", 128'(a1 - a0), 128'd6);
    wait_drain();

    // Reset at step 2 aborts the block; nothing is pushed for it.
    send(KNOWN_IN, a0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_D_out", D_out, '0);
    #2 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_output", 128'(out_valid), 128'd0);
    end
    @(posedge clk); #1;
    exp_q.push_back(B53_OUT);
    send(B53_IN, a0);
    wait_drain();

    // Lane sweep: one-cycle pulses while all sweep instances are idle.
    s_D_in = KNOWN_IN; s_exp = KNOWN_OUT; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    s_D_in = B53_IN; s_exp = B53_OUT; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    check("sw1_count", 128'(sw[0].n_got), 128'd2);
    check("sw2_count", 128'(sw[1].n_got), 128'd2);
    check("sw8_count", 128'(sw[2].n_got), 128'd2);
    check("sw16_count", 128'(sw[3].n_got), 128'd2);
    check("main_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
